// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, the latched
// request layout and the bus widths used by the arbiter and its interface.
package mem_port_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MBE_WIDTH  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INST,
        ARB_DATA
    } arb_state_t;

    // One outstanding request as it is presented on the shared memory port.
    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [MBE_WIDTH-1:0]  mbe;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    // An all-zero request means the port is quiet.
    localparam mem_req_t REQ_NONE = '0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// The slave view is the arbiter itself; the master view is everything around
// it (core requesters plus the memory hierarchy).
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                  flush_i;

    logic                  inst_read_i;
    logic [ADDR_WIDTH-1:0] inst_addr_i;
    logic                  inst_resp_o;
    logic [DATA_WIDTH-1:0] inst_rdata_o;

    logic                  data_read_i;
    logic                  data_write_i;
    logic [MBE_WIDTH-1:0]  data_mbe_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_resp_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;

    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [MBE_WIDTH-1:0]  mem_mbe_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_resp_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  flush_i,
        input  inst_read_i, inst_addr_i,
        output inst_resp_o, inst_rdata_o,
        input  data_read_i, data_write_i, data_mbe_i, data_addr_i, data_wdata_i,
        output data_resp_o, data_rdata_o,
        output mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, mem_wdata_o,
        input  mem_resp_i, mem_rdata_i
    );

    modport master (
        output flush_i,
        output inst_read_i, inst_addr_i,
        input  inst_resp_o, inst_rdata_o,
        output data_read_i, data_write_i, data_mbe_i, data_addr_i, data_wdata_i,
        input  data_resp_o, data_rdata_o,
        input  mem_read_o, mem_write_o, mem_mbe_o, mem_addr_o, mem_wdata_o,
        output mem_resp_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Data wins by default; after STARVE_LIMIT data grants with a fetch waiting,
// the fetch is forced through. A flushed fetch still completes on the port
// but its response is swallowed.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    mem_req_t         req_q, req_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             squash_q, squash_d;

    logic             data_pending;
    logic             fetch_starved;

    assign data_pending  = bus.data_read_i | bus.data_write_i;
    assign fetch_starved = bus.inst_read_i && (starve_cnt_q == CNT_MAX);

    // Next-state, grant, starvation and squash decisions.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        squash_d     = squash_q;
        starve_cnt_d = bus.inst_read_i ? starve_cnt_q : '0;

        case (state_q)
            ARB_IDLE: begin
                if (data_pending && !fetch_starved) begin
                    state_d       = ARB_DATA;
                    req_d.write   = bus.data_write_i;
                    req_d.read    = bus.data_read_i && !bus.data_write_i;
                    req_d.mbe     = bus.data_mbe_i;
                    req_d.addr    = bus.data_addr_i;
                    req_d.wdata   = bus.data_wdata_i;
                    if (bus.inst_read_i) begin
                        starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX
                                                                 : starve_cnt_q + CNT_W'(1);
                    end
                end else if (bus.inst_read_i) begin
                    state_d      = ARB_INST;
                    req_d.read   = 1'b1;
                    req_d.write  = 1'b0;
                    req_d.mbe    = '0;
                    req_d.addr   = bus.inst_addr_i;
                    req_d.wdata  = '0;
                    starve_cnt_d = '0;
                    squash_d     = bus.flush_i;
                end
            end
            ARB_INST: begin
                if (bus.mem_resp_i) begin
                    state_d  = ARB_IDLE;
                    req_d    = REQ_NONE;
                    squash_d = 1'b0;
                end else if (bus.flush_i) begin
                    squash_d = 1'b1;
                end
            end
            ARB_DATA: begin
                if (bus.mem_resp_i) begin
                    state_d = ARB_IDLE;
                    req_d   = REQ_NONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                req_d   = REQ_NONE;
            end
        endcase
    end

    // Register the FSM, the latched port request, starvation count and squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            req_q        <= REQ_NONE;
            starve_cnt_q <= '0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            starve_cnt_q <= starve_cnt_d;
            squash_q     <= squash_d;
        end
    end

    assign bus.mem_read_o   = req_q.read;
    assign bus.mem_write_o  = req_q.write;
    assign bus.mem_mbe_o    = req_q.mbe;
    assign bus.mem_addr_o   = req_q.addr;
    assign bus.mem_wdata_o  = req_q.wdata;

    assign bus.inst_rdata_o = bus.mem_rdata_i;
    assign bus.data_rdata_o = bus.mem_rdata_i;
    assign bus.inst_resp_o  = (state_q == ARB_INST) && bus.mem_resp_i && !squash_q;
    assign bus.data_resp_o  = (state_q == ARB_DATA) && bus.mem_resp_i;

    // A load and a store at once is a requester bug; the RTL treats it as a store.
    illegal_data_op: assert property (@(posedge clk) disable iff (rst)
        !(bus.data_read_i && bus.data_write_i));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all watched every cycle by a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    typedef enum {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

    logic clk;
    logic rst;

    int assert_count = 0;
    int fail_count   = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the port, what it put there, how many data
    // grants in a row the fetch has had to watch, and whether the fetch is dead.
    owner_e      m_owner = OWN_NONE;
    logic        m_read = 1'b0, m_write = 1'b0;
    logic [3:0]  m_mbe = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    int          m_streak = 0;
    bit          m_squash = 1'b0;
    bit          model_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic clear_model_port();
        m_owner = OWN_NONE;
        m_read  = 1'b0;
        m_write = 1'b0;
        m_mbe   = '0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    // Compare process: check outputs mid-cycle, then advance the model with the
    // inputs that the coming rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                checkOutput("model_mem_read",   32'(bus.mem_read_o),  32'(m_read));
                checkOutput("model_mem_write",  32'(bus.mem_write_o), 32'(m_write));
                checkOutput("model_mem_mbe",    32'(bus.mem_mbe_o),   32'(m_mbe));
                checkOutput("model_mem_addr",   bus.mem_addr_o,       m_addr);
                checkOutput("model_mem_wdata",  bus.mem_wdata_o,      m_wdata);
                checkOutput("model_inst_resp",  32'(bus.inst_resp_o),
                            32'((m_owner == OWN_INST) && bus.mem_resp_i && !m_squash));
                checkOutput("model_data_resp",  32'(bus.data_resp_o),
                            32'((m_owner == OWN_DATA) && bus.mem_resp_i));
                checkOutput("model_inst_rdata", bus.inst_rdata_o, bus.mem_rdata_i);
                checkOutput("model_data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
            end
            if (rst) begin
                clear_model_port();
                m_streak    = 0;
                m_squash    = 1'b0;
                model_valid = 1'b1;
            end else begin
                int next_streak;
                next_streak = bus.inst_read_i ? m_streak : 0;
                case (m_owner)
                    OWN_NONE: begin
                        if ((bus.data_read_i || bus.data_write_i) &&
                            !(bus.inst_read_i && m_streak == LIMIT)) begin
                            m_owner = OWN_DATA;
                            m_write = bus.data_write_i;
                            m_read  = bus.data_read_i && !bus.data_write_i;
                            m_mbe   = bus.data_mbe_i;
                            m_addr  = bus.data_addr_i;
                            m_wdata = bus.data_wdata_i;
                            if (bus.inst_read_i)
                                next_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
                        end else if (bus.inst_read_i) begin
                            m_owner     = OWN_INST;
                            m_read      = 1'b1;
                            m_write     = 1'b0;
                            m_mbe       = '0;
                            m_addr      = bus.inst_addr_i;
                            m_wdata     = '0;
                            next_streak = 0;
                            m_squash    = bus.flush_i;
                        end
                    end
                    OWN_INST: begin
                        if (bus.mem_resp_i) begin
                            clear_model_port();
                            m_squash = 1'b0;
                        end else if (bus.flush_i) begin
                            m_squash = 1'b1;
                        end
                    end
                    OWN_DATA: begin
                        if (bus.mem_resp_i) clear_model_port();
                    end
                    default: clear_model_port();
                endcase
                m_streak = next_streak;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
    endtask

    // Random-phase requester and memory state.
    bit saw_inst  = 1'b0;
    bit saw_data  = 1'b0;
    bit inst_pend = 1'b0;
    int data_kind = 0;

    // One cycle of random traffic: a memory with random latency and spurious
    // idle responses, a fetch unit that drops its request after a flush, and a
    // load/store unit that scrambles address/data while waiting.
    task automatic applyStimulus();
        if (bus.mem_resp_i)
            bus.mem_resp_i = 1'b0;
        else if (bus.mem_read_o || bus.mem_write_o)
            bus.mem_resp_i = ($urandom_range(0, 2) == 0);
        else
            bus.mem_resp_i = ($urandom_range(0, 7) == 0);
        bus.mem_rdata_i = $urandom();

        if (saw_inst) inst_pend = 1'b0;
        if (bus.flush_i) begin
            bus.flush_i = 1'b0;
            inst_pend   = 1'b0;
        end else begin
            if (!inst_pend && $urandom_range(0, 2) == 0) begin
                inst_pend       = 1'b1;
                bus.inst_addr_i = $urandom();
            end
            bus.flush_i = ($urandom_range(0, 14) == 0);
        end
        bus.inst_read_i = inst_pend;

        if (saw_data) data_kind = 0;
        if (data_kind == 0 && $urandom_range(0, 1) == 0) data_kind = $urandom_range(1, 2);
        bus.data_read_i  = (data_kind == 1);
        bus.data_write_i = (data_kind == 2);
        bus.data_addr_i  = $urandom();
        bus.data_wdata_i = $urandom();
        bus.data_mbe_i   = 4'($urandom());
    endtask

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        int  data_tx;
        bit  fetch_seen;
        bit  respond_next;

        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.inst_read_i = 1'b0;  bus.inst_addr_i = '0;
        bus.data_read_i = 1'b0;  bus.data_write_i = 1'b0;
        bus.data_mbe_i = '0;     bus.data_addr_i = '0;  bus.data_wdata_i = '0;
        bus.mem_resp_i = 1'b0;   bus.mem_rdata_i = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mid_cycle();
        checkOutput("reset_mem_read",  32'(bus.mem_read_o),  32'h0);
        checkOutput("reset_mem_write", 32'(bus.mem_write_o), 32'h0);
        checkOutput("reset_mem_addr",  bus.mem_addr_o,       32'h0);
        checkOutput("reset_inst_resp", 32'(bus.inst_resp_o), 32'h0);
        checkOutput("reset_data_resp", 32'(bus.data_resp_o), 32'h0);

        // Lone fetch: request at t, port at t+1..t+3, response at t+3.
        next_cycle();
        bus.inst_read_i = 1'b1; bus.inst_addr_i = 32'h60;
        mid_cycle();
        checkOutput("fetch_port_quiet_t", 32'(bus.mem_read_o), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 3) begin
                bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'h00A00093;
            end
            mid_cycle();
            checkOutput("fetch_mem_read", 32'(bus.mem_read_o), 32'h1);
            checkOutput("fetch_mem_addr", bus.mem_addr_o, 32'h60);
        end
        checkOutput("fetch_inst_resp",  32'(bus.inst_resp_o), 32'h1);
        checkOutput("fetch_inst_rdata", bus.inst_rdata_o, 32'h00A00093);
        checkOutput("fetch_no_data_resp", 32'(bus.data_resp_o), 32'h0);
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.inst_read_i = 1'b0;
        mid_cycle();
        checkOutput("fetch_port_idle_t4", 32'(bus.mem_read_o), 32'h0);

        // Contention: data first, fetch on the port at r+2.
        next_cycle();
        bus.inst_read_i = 1'b1; bus.inst_addr_i = 32'h64;
        bus.data_read_i = 1'b1; bus.data_addr_i = 32'h100;
        next_cycle();
        mid_cycle();
        checkOutput("contend_data_first", bus.mem_addr_o, 32'h100);
        next_cycle();
        bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'h11112222;
        mid_cycle();
        checkOutput("contend_data_resp", 32'(bus.data_resp_o), 32'h1);
        checkOutput("contend_data_rdata", bus.data_rdata_o, 32'h11112222);
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.data_read_i = 1'b0;
        mid_cycle();
        checkOutput("contend_idle_r1", 32'(bus.mem_read_o), 32'h0);
        next_cycle();
        mid_cycle();
        checkOutput("contend_fetch_r2", bus.mem_addr_o, 32'h64);
        next_cycle();
        bus.mem_resp_i = 1'b1;
        mid_cycle();
        checkOutput("contend_fetch_resp", 32'(bus.inst_resp_o), 32'h1);
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.inst_read_i = 1'b0;

        // Starvation: fetch held, data always asking; expect four data then the fetch.
        next_cycle();
        bus.inst_read_i = 1'b1; bus.inst_addr_i = 32'h80;
        bus.data_read_i = 1'b1; bus.data_addr_i = 32'h300;
        data_tx = 0; fetch_seen = 1'b0; respond_next = 1'b0;
        for (int n = 0; n < 40 && !fetch_seen; n++) begin
            mid_cycle();
            if ((bus.mem_read_o || bus.mem_write_o) && !bus.mem_resp_i) begin
                respond_next = 1'b1;
                if (bus.mem_addr_o == 32'h80) fetch_seen = 1'b1;
                else data_tx++;
            end
            next_cycle();
            bus.mem_resp_i  = respond_next;
            respond_next    = 1'b0;
            bus.data_addr_i = 32'h300 + 32'(n * 4);
        end
        checkOutput("starve_fetch_granted", 32'(fetch_seen), 32'h1);
        checkOutput("starve_data_tx", 32'(data_tx), 32'd4);
        mid_cycle();
        checkOutput("starve_fetch_resp", 32'(bus.inst_resp_o), 32'h1);
        // Fetch stays up with a new address: data must win again, so the count restarted.
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.inst_addr_i = 32'h84; bus.data_addr_i = 32'h400;
        next_cycle();
        mid_cycle();
        checkOutput("starve_cnt_cleared", bus.mem_addr_o, 32'h400);
        next_cycle();
        bus.mem_resp_i = 1'b1;
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.data_read_i = 1'b0;
        next_cycle();
        mid_cycle();
        checkOutput("starve_next_fetch", bus.mem_addr_o, 32'h84);
        next_cycle();
        bus.mem_resp_i = 1'b1;
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.inst_read_i = 1'b0;

        // Store: latched values survive the requester scrambling its inputs.
        next_cycle();
        bus.data_write_i = 1'b1; bus.data_addr_i = 32'h200;
        bus.data_mbe_i = 4'b0011; bus.data_wdata_i = 32'hDEADBEEF;
        next_cycle();
        mid_cycle();
        checkOutput("store_mem_write", 32'(bus.mem_write_o), 32'h1);
        checkOutput("store_mem_read",  32'(bus.mem_read_o),  32'h0);
        checkOutput("store_mem_mbe",   32'(bus.mem_mbe_o),   32'h3);
        checkOutput("store_mem_wdata", bus.mem_wdata_o,      32'hDEADBEEF);
        next_cycle();
        bus.data_addr_i = 32'h0; bus.data_wdata_i = 32'h0; bus.data_mbe_i = 4'h0;
        mid_cycle();
        checkOutput("store_addr_held", bus.mem_addr_o, 32'h200);
        next_cycle();
        bus.mem_resp_i = 1'b1;
        mid_cycle();
        checkOutput("store_data_resp", 32'(bus.data_resp_o), 32'h1);
        checkOutput("store_no_inst_resp", 32'(bus.inst_resp_o), 32'h0);
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.data_write_i = 1'b0;

        // Flush squash: flush at t+2, fetch dropped at t+3, response swallowed.
        next_cycle();
        bus.inst_read_i = 1'b1; bus.inst_addr_i = 32'h40;
        next_cycle();
        next_cycle();
        bus.flush_i = 1'b1;
        next_cycle();
        bus.flush_i = 1'b0; bus.inst_read_i = 1'b0;
        mid_cycle();
        checkOutput("flush_read_held", 32'(bus.mem_read_o), 32'h1);
        next_cycle();
        bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
        mid_cycle();
        checkOutput("flush_squashed", 32'(bus.inst_resp_o), 32'h0);
        next_cycle();
        bus.mem_resp_i = 1'b0;
        next_cycle();
        bus.inst_read_i = 1'b1; bus.inst_addr_i = 32'h44;
        next_cycle();
        next_cycle();
        bus.mem_resp_i = 1'b1; bus.mem_rdata_i = 32'h0BADF00D;
        mid_cycle();
        checkOutput("flush_next_fetch_resp", 32'(bus.inst_resp_o), 32'h1);
        next_cycle();
        bus.mem_resp_i = 1'b0; bus.inst_read_i = 1'b0;

        // Reset while a load is on the port; a late response is ignored.
        next_cycle();
        bus.data_read_i = 1'b1; bus.data_addr_i = 32'h500;
        next_cycle();
        mid_cycle();
        checkOutput("rstmid_load_on_port", bus.mem_addr_o, 32'h500);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; bus.data_read_i = 1'b0; bus.mem_resp_i = 1'b1;
        mid_cycle();
        checkOutput("rstmid_mem_read", 32'(bus.mem_read_o), 32'h0);
        checkOutput("rstmid_mem_addr", bus.mem_addr_o, 32'h0);
        checkOutput("rstmid_data_resp", 32'(bus.data_resp_o), 32'h0);
        next_cycle();
        bus.mem_resp_i = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            mid_cycle();
            saw_inst = bus.inst_resp_o;
            saw_data = bus.data_resp_o;
            next_cycle();
            applyStimulus();
        end

        next_cycle();
        bus.inst_read_i = 1'b0; bus.data_read_i = 1'b0; bus.data_write_i = 1'b0;
        bus.flush_i = 1'b0; bus.mem_resp_i = 1'b0;
        repeat (6) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
